// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared definitions for the divider-sharing arbiter.
//   arb_state_t : FSM state encoding (3 bits).
//   DIV_ZERO_Q  : all-ones quotient returned for a bypassed divide-by-zero.
//                 It is declared wide and sliced to N bits by the user.
package div_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_RSP   = 3'd4
    } arb_state_t;

    localparam int DIV_Q_MAX_W = 1024;

    // Slice as DIV_ZERO_Q[N-1:0] to get an N-bit all-ones quotient.
    localparam logic [DIV_Q_MAX_W-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_share_arb_rr_pick.sv
// rr_pick: combinational circular priority picker.
//   req      [NREQ-1:0] : pending requests
//   last     [IDW-1:0]  : index of the previous winner
//   grant    [NREQ-1:0] : one-hot winner, first set bit strictly after last
//   grant_id [IDW-1:0]  : binary index of the winner
//   any                 : at least one request pending
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic           found;
    logic [IDW-1:0] idx;

    // Visit offsets 1..NREQ from last; offset NREQ is last itself, so a lone
    // requester that won the previous round still gets picked.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last) + 32'(k)) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin arbiter/sequencer sharing one multi-cycle divider
// among NREQ requesters.
//
// Optional feature: define DIV_ZERO_BYPASS_EN to answer divisor==0 requests
// directly (quotient all ones, remainder = dividend[M-1:0]) without using
// the divider.
//
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready       : per-requester request and one-hot grant pulse
//   req_dividend/req_divisor  : packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready       : result handshake
//   rsp_id/rsp_quotient/rsp_remainder : result and owner
//   busy                      : high whenever the FSM is not in IDLE
//   div_clr/div_start         : divider clear level and start pulse
//   div_dividend/div_divisor  : latched operands to the divider
//   div_quotient/div_remainder/div_done : divider results (done is a level)
module div_share_arb
    import div_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int N    = 64,
    parameter  int M    = 64,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_quotient,
    output logic [M-1:0]      rsp_remainder,
    output logic              busy,
    output logic              div_clr,
    output logic              div_start,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    input  logic [N-1:0]      div_quotient,
    input  logic [M-1:0]      div_remainder,
    input  logic              div_done
);

    arb_state_t      state;
    logic [IDW-1:0]  last_ptr;
    logic            arm;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_id;
    logic            pick_any;
    logic            grant_fire;

    logic [N-1:0]    dividend_arr [NREQ];
    logic [N-1:0]    divisor_arr  [NREQ];
    logic [N-1:0]    sel_dividend;
    logic [N-1:0]    sel_divisor;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = req_dividend[gi*N +: N];
            assign divisor_arr[gi]  = req_divisor[gi*N +: N];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req      (req_valid),
        .last     (last_ptr),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    assign sel_dividend = dividend_arr[pick_id];
    assign sel_divisor  = divisor_arr[pick_id];

    // arm is low while rst is asserted (and for the first cycle after), so a
    // grant pulse can never appear while the FSM is unable to take operands.
    assign grant_fire = (state == ST_IDLE) && arm && pick_any;
    assign req_ready  = grant_fire ? pick_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            last_ptr      <= IDW'(NREQ - 1);
            arm           <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            busy          <= 1'b0;
            div_clr       <= 1'b1;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
        end else begin
            arm       <= 1'b1;
            // Clear and start are single-cycle pulses; states raise them.
            div_clr   <= 1'b0;
            div_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_fire) begin
                        last_ptr     <= pick_id;
                        rsp_id       <= pick_id;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        busy         <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= DIV_ZERO_Q[N-1:0];
                            rsp_remainder <= sel_dividend[M-1:0];
                            rsp_valid     <= 1'b1;
                            state         <= ST_RSP;
                        end else begin
                            div_clr <= 1'b1;
                            state   <= ST_CLR;
                        end
`else
                        div_clr <= 1'b1;
                        state   <= ST_CLR;
`endif
                    end
                end
                ST_CLR: begin
                    div_start <= 1'b1;
                    state     <= ST_START;
                end
                ST_START: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    // done can only be fresh here: CLR wiped the old level.
                    if (div_done) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
